// File: rtl/x_cmd_initiator.sv
// Host-side initiator for the 64-bit UART command protocol: sends one command as 8 bytes,
// optionally waits for a single reply byte, and reports done / reply / timeout.
//
// Handshakes: a transfer happens on a cycle where valid and the matching accept are both high.
// The valid side holds its data stable until that cycle. Strobe inputs (i_rx_valid) are
// single-cycle and have no back-pressure.
module x_cmd_initiator #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int RSP_BIT   = 60,
  parameter int TO_W      = 16,
  parameter int TO_CYCLES = 50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_accept,
  input  logic [63:0] i_cmd,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_accept,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_done,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_data,
  output logic        o_timeout,
  output logic        o_busy,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

  state_t          state;
  logic [63:0]     sreg;
  logic            rsp_req;
  logic [2:0]      count;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state       <= IDLE;
      sreg        <= '0;
      rsp_req     <= 1'b0;
      count       <= '0;
      to_cnt      <= '0;
      o_tx_valid  <= 1'b0;
      o_done      <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_data  <= '0;
      o_timeout   <= 1'b0;
    end else begin
      o_done      <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_timeout   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            sreg       <= i_cmd;
            rsp_req    <= i_cmd[RSP_BIT];
            count      <= '0;
            o_tx_valid <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (i_tx_accept) begin
            sreg  <= MSB_FIRST ? {sreg[55:0], 8'h00} : {8'h00, sreg[63:8]};
            count <= count + 3'd1;
            if (count == 3'd7) begin
              o_tx_valid <= 1'b0;
              if (rsp_req) begin
                to_cnt <= '0;
                state  <= WAIT_RSP;
              end else begin
                o_done <= 1'b1;
                state  <= DONE;
              end
            end
          end
        end
        WAIT_RSP: begin
          // A reply arriving on the final timeout cycle still counts as a reply.
          if (i_rx_valid) begin
            o_rsp_data  <= i_rx_data;
            o_rsp_valid <= 1'b1;
            o_done      <= 1'b1;
            state       <= DONE;
          end else if (to_cnt == TO_LAST) begin
            o_timeout <= 1'b1;
            o_done    <= 1'b1;
            state     <= DONE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_tx_data = MSB_FIRST ? sreg[63:56] : sreg[7:0];
  assign o_accept  = (state == IDLE);
  assign o_busy    = (state != IDLE);
  assign o_state   = state;

endmodule

// File: tb/tb_x_cmd_initiator.sv
// Bench for x_cmd_initiator: table of command transactions checked against hand-computed
// byte order / completion timing, plus hand sequences for reset abort and busy behaviour.
module tb_x_cmd_initiator;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_valid = 1'b0;
  logic [63:0] i_cmd = '0;
  logic        i_tx_accept = 1'b0;
  logic        i_rx_valid = 1'b0;
  logic [7:0]  i_rx_data = '0;

  logic        o_accept, o_tx_valid, o_done, o_rsp_valid, o_timeout, o_busy;
  logic [7:0]  o_tx_data, o_rsp_data;
  logic [1:0]  o_state;
  logic        l_accept, l_tx_valid, l_done, l_rsp_valid, l_timeout, l_busy;
  logic [7:0]  l_tx_data, l_rsp_data;
  logic [1:0]  l_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] lsb_q[$];

  x_cmd_initiator #(.MSB_FIRST(1'b1), .RSP_BIT(60), .TO_W(16), .TO_CYCLES(100)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_accept(o_accept), .i_cmd(i_cmd),
    .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .i_tx_accept(i_tx_accept),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_done(o_done),
    .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_timeout(o_timeout),
    .o_busy(o_busy), .o_state(o_state)
  );

  x_cmd_initiator #(.MSB_FIRST(1'b0), .RSP_BIT(60), .TO_W(16), .TO_CYCLES(100)) dut_lsb (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_accept(l_accept), .i_cmd(i_cmd),
    .o_tx_valid(l_tx_valid), .o_tx_data(l_tx_data), .i_tx_accept(i_tx_accept),
    .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_done(l_done),
    .o_rsp_valid(l_rsp_valid), .o_rsp_data(l_rsp_data), .o_timeout(l_timeout),
    .o_busy(l_busy), .o_state(l_state)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] cmd;
    int          period;     // i_tx_accept high one cycle in `period`
    bit          reply_en;
    int          reply_dly;  // cycles after WAIT_RSP entry before the reply strobe
    logic [7:0]  rx_byte;
    int          exp_wait;   // cycles from end of SEND until o_done is seen
    bit          exp_rv;
    bit          exp_to;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver + scoreboard for one full command
  task automatic run_cmd(input vec_t v);
    int   cyc;
    int   waited;
    logic acc;
    exp_q.delete();
    lsb_q.delete();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(v.cmd[63-8*i -: 8]);
      lsb_q.push_back(v.cmd[8*i +: 8]);
    end
    check("accept_idle", o_accept, 1);
    i_valid = 1'b1;
    i_cmd   = v.cmd;
    tick();
    i_valid = 1'b0;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      acc = ((cyc % v.period) == v.period - 1);
      i_tx_accept = acc;
      check("tx_valid", o_tx_valid, 1);
      check("tx_data", o_tx_data, exp_q[0]);
      check("lsb_tx_data", l_tx_data, lsb_q[0]);
      check("busy", o_busy, 1);
      check("accept_busy", o_accept, 0);
      if (acc) begin
        void'(exp_q.pop_front());
        void'(lsb_q.pop_front());
      end
      tick();
      cyc++;
    end
    i_tx_accept = 1'b0;
    check("bytes_sent", exp_q.size(), 0);
    check("send_cycles", cyc, 8 * v.period);
    check("tx_valid_drop", o_tx_valid, 0);
    waited = 0;
    while (!o_done && waited < 300) begin
      i_rx_valid = v.reply_en && (waited == v.reply_dly);
      i_rx_data  = v.rx_byte;
      tick();
      waited++;
    end
    i_rx_valid = 1'b0;
    check("done_latency", waited, v.exp_wait);
    check("done", o_done, 1);
    check("lsb_done", l_done, 1);
    check("rsp_valid", o_rsp_valid, v.exp_rv);
    check("timeout", o_timeout, v.exp_to);
    check("rsp_data", o_rsp_data, v.exp_data);
    tick();
    check("done_pulse", o_done, 0);
    check("rsp_valid_pulse", o_rsp_valid, 0);
    check("accept_after", o_accept, 1);
  endtask

  initial begin
    vecs[0] = '{64'h0123_4567_89AB_CDEF, 1, 1'b0, 0,  8'h00, 0,   1'b0, 1'b0, 8'h00};
    vecs[1] = '{64'h0123_4567_89AB_CDEF, 4, 1'b0, 0,  8'h00, 0,   1'b0, 1'b0, 8'h00};
    vecs[2] = '{64'h1000_0000_0000_0000, 1, 1'b1, 20, 8'h5A, 21,  1'b1, 1'b0, 8'h5A};
    vecs[3] = '{64'h1000_0000_0000_0000, 2, 1'b0, 0,  8'h00, 100, 1'b0, 1'b1, 8'h5A};
    vecs[4] = '{64'h1000_0000_0000_00FF, 1, 1'b1, 99, 8'hC3, 100, 1'b1, 1'b0, 8'hC3};
    vecs[5] = '{64'hF0E1_D2C3_B4A5_9687, 1, 1'b1, 0,  8'h11, 1,   1'b1, 1'b0, 8'h11};
    vecs[6] = '{64'hEFFF_0000_1234_5678, 3, 1'b0, 0,  8'h00, 0,   1'b0, 1'b0, 8'h11};

    // reset state
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_tx_valid", o_tx_valid, 0);
    check("rst_done", o_done, 0);
    check("rst_rsp_valid", o_rsp_valid, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_busy", o_busy, 0);
    check("rst_rsp_data", o_rsp_data, 0);
    check("rst_state", o_state, 0);
    i_rst = 1'b1;
    tick();
    check("rst_accept", o_accept, 1);

    // i_valid held while busy, stray reply byte during SEND must be ignored
    i_valid = 1'b1;
    i_cmd   = 64'h2233_4455_6677_8899;
    tick();
    for (int c = 0; c < 16; c++) begin
      i_tx_accept = c[0];
      i_rx_valid  = (c == 4);
      i_rx_data   = 8'h77;
      check("hold_accept_low", o_accept, 0);
      tick();
    end
    i_tx_accept = 1'b0;
    i_rx_valid  = 1'b0;
    check("hold_done", o_done, 1);
    check("hold_accept_done", o_accept, 0);
    check("stray_rsp_valid", o_rsp_valid, 0);
    check("stray_rsp_data", o_rsp_data, 0);
    i_valid = 1'b0;
    tick();
    check("hold_accept_idle", o_accept, 1);
    check("hold_done_pulse", o_done, 0);

    // table-driven transactions
    for (int k = 0; k < 7; k++) run_cmd(vecs[k]);

    // reset after 3rd byte accepted aborts the command
    i_valid = 1'b1;
    i_cmd   = 64'hA1B2_C3D4_E5F6_0718;
    tick();
    i_valid     = 1'b0;
    i_tx_accept = 1'b1;
    repeat (3) tick();
    check("mid_tx_data", o_tx_data, 8'hD4);
    #2;
    i_rst = 1'b0;
    #1;
    check("abort_tx_valid", o_tx_valid, 0);
    check("abort_lsb_tx_valid", l_tx_valid, 0);
    check("abort_busy", o_busy, 0);
    check("abort_done", o_done, 0);
    check("abort_rsp_data", o_rsp_data, 0);
    check("abort_state", o_state, 0);
    i_tx_accept = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    tick();
    check("abort_no_done", o_done, 0);
    run_cmd('{64'hA1B2_C3D4_E5F6_0718, 1, 1'b0, 0, 8'h00, 0, 1'b0, 1'b0, 8'h00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
